traffic_phase_sequencer: RTL and testbench
==========================================

# traffic_phase_sequencer

Timed phase controller for the two-road (main/side) traffic light with a pedestrian crossing. A prescaler converts the board clock into a one-cycle tick enable; the design uses no derived clock. A Moore FSM sequences the green/yellow/all-red phases and a walk phase, with durations counted in ticks. The block sits between the board clock/reset and the lamp drivers.

## Interface
- TICK_DIV, 50_000_000: clock_in cycles per tick; must be ≥1.
- MIN_GREEN, 10: minimum MAIN_GREEN duration in ticks; ≥1.
- YELLOW_T, 3: duration in ticks of each yellow phase; ≥1.
- ALLRED_T, 1: duration in ticks of each all-red phase; ≥1.
- SIDE_T, 8: SIDE_GREEN duration in ticks; ≥1.
- WALK_T, 6: PED_WALK duration in ticks; ≥1.

Ports:
- clock_in  in  1  system clock.
- reset  in  1  synchronous, active-high.
- side_car  in  1  level input; a vehicle is waiting on the side road.
- ped_req  in  1  single-cycle pedestrian button pulse.
- ped_ack  out  1  single-cycle pulse on entry to PED_WALK.
- main_light  out  3  {red,yellow,green}, one-hot.
- side_light  out  3  {red,yellow,green}, one-hot.
- walk  out  1  pedestrian walk lamp.
- tick  out  1  prescaler enable, exported for debug and display.
- phase  out  3  current state encoding.

## Operation
- Prescaler: counter runs 0..TICK_DIV-1 and wraps. `tick`=1 while counter==TICK_DIV-1. With TICK_DIV=1, tick is constant 1.
- Phase timer: cleared to 0 on every state change. On each tick:
  - if timer==DUR-1, the FSM transitions;
  - otherwise the timer increments.
  - No state or timer change occurs without a tick.
- States (encoding 0..6), with their outputs:
  - ALL_RED_2 (reset state): main 100, side 100.
  - MAIN_GREEN: main 001, side 100.
  - MAIN_YELLOW: main 010, side 100.
  - ALL_RED_1: main 100, side 100.
  - SIDE_GREEN: main 100, side 001.
  - SIDE_YELLOW: main 100, side 010.
  - PED_WALK: both 100, walk=1.
  - walk=0 in every state except PED_WALK.
- Transitions:
  - ALL_RED_2 → MAIN_GREEN after ALLRED_T ticks.
  - MAIN_GREEN → MAIN_YELLOW at the first tick where timer==MIN_GREEN-1 and (side_car or ped_pending). With no demand, the timer saturates at MIN_GREEN-1 and the FSM re-checks on every tick.
  - MAIN_YELLOW → ALL_RED_1 after YELLOW_T ticks.
  - ALL_RED_1 → PED_WALK if ped_pending, else SIDE_GREEN, after ALLRED_T ticks. Pedestrian has priority.
  - SIDE_GREEN → SIDE_YELLOW after SIDE_T ticks, regardless of side_car.
  - SIDE_YELLOW → ALL_RED_2 after YELLOW_T ticks.
  - PED_WALK → ALL_RED_2 after WALK_T ticks. Side demand is served on the next round.
- ped_pending:
  - set by ped_req in any state;
  - cleared on entry to PED_WALK;
  - if set and clear occur in the same cycle, set wins and the request stays pending;
  - ped_req during PED_WALK is latched for the next round.
- side_car is sampled only at the MAIN_GREEN decision tick and is not latched.
- Encoding safety: an unused state encoding forces ALL_RED_2 with timer=0.

## Timing
- Reset values:
  - prescaler 0, timer 0, state ALL_RED_2, ped_pending 0;
  - main_light=100, side_light=100;
  - walk=0, ped_ack=0, tick=0 (TICK_DIV>1), phase=0.
- Outputs are decoded from the registered state. They change on the clock edge where tick=1 and the transition condition holds, with no additional latency.
- First tick: tick is high during the TICK_DIV-th cycle after reset release. The first transition appears after TICK_DIV edges. A phase of D ticks lasts exactly D·TICK_DIV cycles.
- ped_ack is high for exactly the first cycle of PED_WALK.
- Reset mid-phase forces the reset state on the next edge; any pending pedestrian request is discarded.

## Structure
- Shared package (traffic_pkg):
  - state enum / localparams;
  - lamp encodings RED=3'b100, YEL=3'b010, GRN=3'b001.
- Sub-module tick_gen (parameter TICK_DIV; ports clock_in, reset, tick) holds the prescaler.
- Counter widths are derived with $clog2 of the largest value each counter must hold.

## Test plan
All scenarios use TICK_DIV=4, MIN_GREEN=3, YELLOW_T=2, ALLRED_T=1, SIDE_T=3, WALK_T=2.
- Reset release, no demand: main 100 for 4 cycles, then main 001 indefinitely (checked for 200 cycles); tick period 4.
- side_car held 1: phases last MAIN_GREEN 12, MAIN_YELLOW 8, ALL_RED_1 4, SIDE_GREEN 12, SIDE_YELLOW 8, ALL_RED_2 4 cycles, then repeat; exactly one lamp is lit per road at all times.
- ped_req pulse at cycle 6 with side_car=0: MAIN_GREEN ends at cycle 16; ped_ack pulses once at cycle 28; walk=1 for 8 cycles; then ALL_RED_2 for 4 cycles, then MAIN_GREEN.
- ped_req pulsed in the same cycle as PED_WALK entry, and again mid-walk: ped_ack fires once now, and PED_WALK recurs on the next round.
- side_car=1 and ped_req together: PED_WALK is served first, SIDE_GREEN on the following round.
- reset asserted mid-SIDE_YELLOW with a request pending: next cycle shows all reset values; no PED_WALK follows unless a new ped_req arrives.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encodings, lamp patterns and width helper for the traffic sequencer
package traffic_pkg;
  localparam logic [2:0] ALL_RED_2   = 3'd0;
  localparam logic [2:0] MAIN_GREEN  = 3'd1;
  localparam logic [2:0] MAIN_YELLOW = 3'd2;
  localparam logic [2:0] ALL_RED_1   = 3'd3;
  localparam logic [2:0] SIDE_GREEN  = 3'd4;
  localparam logic [2:0] SIDE_YELLOW = 3'd5;
  localparam logic [2:0] PED_WALK    = 3'd6;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/traffic_phase_sequencer_tick_gen.sv
// tick_gen: prescaler producing a one-cycle tick every TICK_DIV clocks
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock_in,
  input  logic reset,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clock_in)
    if (reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: tick-timed Moore FSM for main/side lights with pedestrian walk
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MIN_GREEN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int SIDE_T    = 8,
  parameter int WALK_T    = 6
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       side_car,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       tick,
  output logic [2:0] phase
);
  localparam int M1 = MIN_GREEN > YELLOW_T ? MIN_GREEN : YELLOW_T;
  localparam int M2 = ALLRED_T > SIDE_T ? ALLRED_T : SIDE_T;
  localparam int M3 = M1 > M2 ? M1 : M2;
  localparam int MAXD = M3 > WALK_T ? M3 : WALK_T;
  localparam int TW = cnt_w(MAXD);
  logic [2:0] state, nxt;
  logic [TW-1:0] timer, last;
  logic ped_pending, done, enter_walk;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock_in(clock_in),
    .reset(reset),
    .tick(tick)
  );
  always_comb begin
    last = state == MAIN_GREEN ? TW'(MIN_GREEN - 1) :
           (state == MAIN_YELLOW || state == SIDE_YELLOW) ? TW'(YELLOW_T - 1) :
           state == SIDE_GREEN ? TW'(SIDE_T - 1) :
           state == PED_WALK ? TW'(WALK_T - 1) : TW'(ALLRED_T - 1);
    done = tick && timer == last;
    // MAIN_GREEN with no demand maps to itself, which holds the timer saturated
    nxt = state == ALL_RED_2   ? MAIN_GREEN :
          state == MAIN_GREEN  ? ((side_car || ped_pending) ? MAIN_YELLOW : MAIN_GREEN) :
          state == MAIN_YELLOW ? ALL_RED_1 :
          state == ALL_RED_1   ? (ped_pending ? PED_WALK : SIDE_GREEN) :
          state == SIDE_GREEN  ? SIDE_YELLOW : ALL_RED_2;
    enter_walk = done && state == ALL_RED_1 && ped_pending;
  end
  always_ff @(posedge clock_in)
    if (reset) begin
      state       <= ALL_RED_2;
      timer       <= '0;
      ped_pending <= 1'b0;
      ped_ack     <= 1'b0;
    end else begin
      ped_pending <= ped_req | (ped_pending & ~enter_walk);
      ped_ack     <= enter_walk;
      if (state > PED_WALK) begin
        state <= ALL_RED_2;
        timer <= '0;
      end else if (done) begin
        if (nxt != state) begin
          state <= nxt;
          timer <= '0;
        end
      end else if (tick) timer <= timer + 1'b1;
    end
  assign main_light = state == MAIN_GREEN ? GRN : state == MAIN_YELLOW ? YEL : RED;
  assign side_light = state == SIDE_GREEN ? GRN : state == SIDE_YELLOW ? YEL : RED;
  assign walk = state == PED_WALK;
  assign phase = state;
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer: scoreboard bench with hand-computed phase change and ped_ack cycles
module tb_traffic_phase_sequencer;
  logic clk = 1'b0, reset = 1'b1, side_car = 1'b0, ped_req = 1'b0;
  logic ped_ack, walk, tick;
  logic [2:0] main_light, side_light, phase;
  typedef struct {int cyc; logic [2:0] ph;} ev_t;
  ev_t eq[$];
  int aq[$];
  int cyc = 0, n = 0, fails = 0;
  logic [2:0] cur = 3'd0;
  logic exp_ack, exp_tick;
  traffic_phase_sequencer #(
    .TICK_DIV(4), .MIN_GREEN(3), .YELLOW_T(2), .ALLRED_T(1), .SIDE_T(3), .WALK_T(2)
  ) dut (
    .clock_in(clk), .reset(reset), .side_car(side_car), .ped_req(ped_req),
    .ped_ack(ped_ack), .main_light(main_light), .side_light(side_light),
    .walk(walk), .tick(tick), .phase(phase)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] t_main(input logic [2:0] p);
    return p == 3'd1 ? 3'b001 : p == 3'd2 ? 3'b010 : 3'b100;
  endfunction
  function automatic logic [2:0] t_side(input logic [2:0] p);
    return p == 3'd4 ? 3'b001 : p == 3'd5 ? 3'b010 : 3'b100;
  endfunction
  // monitor: cyc counts edges since reset release; expected phase follows the queue
  always @(posedge clk) begin
    #1;
    if (reset) begin
      cyc = 0;
      cur = 3'd0;
      n++;
      if (phase !== 3'd0 || main_light !== 3'b100 || side_light !== 3'b100 ||
          walk !== 1'b0 || ped_ack !== 1'b0 || tick !== 1'b0) begin
        fails++;
        $display("FAIL reset_values: phase=%0d main=%b side=%b walk=%b ack=%b tick=%b, required 0 100 100 0 0 0",
                 phase, main_light, side_light, walk, ped_ack, tick);
      end
      n++;
      if (eq.size() != 0 || aq.size() != 0) begin
        fails++;
        $display("FAIL leftover: %0d phase events and %0d acks never seen, required 0", eq.size(), aq.size());
      end
      eq.delete();
      aq.delete();
    end else begin
      cyc++;
      if (eq.size() != 0 && eq[0].cyc == cyc) cur = eq.pop_front().ph;
      exp_ack = aq.size() != 0 && aq[0] == cyc;
      if (exp_ack) void'(aq.pop_front());
      exp_tick = (cyc % 4) == 3;
      n += 7;
      if (phase !== cur) begin
        fails++; $display("FAIL phase @%0d: got %0d, required %0d", cyc, phase, cur);
      end
      if (main_light !== t_main(cur)) begin
        fails++; $display("FAIL main_light @%0d: got %b, required %b", cyc, main_light, t_main(cur));
      end
      if (side_light !== t_side(cur)) begin
        fails++; $display("FAIL side_light @%0d: got %b, required %b", cyc, side_light, t_side(cur));
      end
      if (walk !== (cur == 3'd6)) begin
        fails++; $display("FAIL walk @%0d: got %b, required %b", cyc, walk, cur == 3'd6);
      end
      if (ped_ack !== exp_ack) begin
        fails++; $display("FAIL ped_ack @%0d: got %b, required %b", cyc, ped_ack, exp_ack);
      end
      if (tick !== exp_tick) begin
        fails++; $display("FAIL tick @%0d: got %b, required %b", cyc, tick, exp_tick);
      end
      if (!$onehot(main_light) || !$onehot(side_light)) begin
        fails++; $display("FAIL onehot @%0d: main=%b side=%b, required one lamp each", cyc, main_light, side_light);
      end
    end
  end
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic pulse();
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
  endtask
  task automatic push(input int c, input logic [2:0] p);
    eq.push_back('{cyc: c, ph: p});
  endtask
  task automatic push_list(input int cs[], input logic [2:0] ps[]);
    foreach (cs[i]) push(cs[i], ps[i]);
  endtask
  initial begin
    // no demand: green holds forever
    do_reset();
    push(4, 3'd1);
    wait_cyc(200);
    // side_car held: full side cycle twice
    side_car = 1'b1;
    do_reset();
    push_list('{4, 16, 24, 28, 40, 48, 52, 64, 72, 76, 88, 96, 100},
              '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1});
    wait_cyc(105);
    side_car = 1'b0;
    // single pedestrian request
    do_reset();
    push_list('{4, 16, 24, 28, 36, 40}, '{3'd1, 3'd2, 3'd3, 3'd6, 3'd0, 3'd1});
    aq.push_back(28);
    wait_cyc(6);
    pulse();
    wait_cyc(100);
    // request at walk entry and mid-walk: walk again next round
    do_reset();
    push_list('{4, 16, 24, 28, 36, 40, 52, 60, 64, 72, 76},
              '{3'd1, 3'd2, 3'd3, 3'd6, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd0, 3'd1});
    aq.push_back(28);
    aq.push_back(64);
    wait_cyc(6);
    pulse();
    wait_cyc(27);
    pulse();
    wait_cyc(31);
    pulse();
    wait_cyc(90);
    // side demand and pedestrian together: walk first
    side_car = 1'b1;
    do_reset();
    push_list('{4, 16, 24, 28, 36, 40, 52, 60, 64, 76, 84, 88},
              '{3'd1, 3'd2, 3'd3, 3'd6, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1});
    aq.push_back(28);
    wait_cyc(6);
    pulse();
    wait_cyc(92);
    // reset mid-SIDE_YELLOW discards the pending request
    do_reset();
    push_list('{4, 16, 24, 28, 40}, '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5});
    wait_cyc(30);
    pulse();
    wait_cyc(44);
    side_car = 1'b0;
    do_reset();
    push(4, 3'd1);
    wait_cyc(100);
    do_reset();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
